// File: rtl/dly_pkg.sv
// Shared constants, config record and helpers for the delay/window generator.
// Optional feature macro used by this slice: DLY_EDGE_EN (rising-edge detect on inputs).
package dly_pkg;

  localparam int unsigned NCHAN_DEF = 4;
  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned WW_DEF    = 4;
  localparam int unsigned DW_DEF    = $clog2(DEPTH_DEF);

  // Per-channel config record at the default geometry.
  typedef struct packed {
    logic [DW_DEF-1:0] delay;
    logic [WW_DEF-1:0] width;
  } cfg_t;

  // Saturate a requested delay to the last tap of a DEPTH-tap line.
  function automatic int unsigned clamp_delay(input int unsigned req, input int unsigned depth);
    return (req > depth - 1) ? depth - 1 : req;
  endfunction

endpackage

// File: rtl/dly_chan.sv
// One channel: optional rising-edge detector, DEPTH-tap shift line, tap mux and
// retriggerable window counter. Macro: DLY_EDGE_EN adds a registered edge detector.
module dly_chan
  import dly_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned WW    = WW_DEF,
  parameter int unsigned DW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          din_i,
  input  logic [DW-1:0] delay_i,
  input  logic [WW-1:0] width_i,
  input  logic          clear_i,
  input  logic          flush_i,
  output logic          dly_o,
  output logic          win_o
);

  logic [DEPTH-1:0] line_q, line_d;
  logic [WW-1:0]    cnt_q, cnt_d;
  logic             dly_q, dly_d;
  logic             win_q, win_d;
  logic             line_in;
  logic             tap;

`ifdef DLY_EDGE_EN
  logic prev_q;
  logic edge_q;

  // Register a one-cycle event on each rising edge of the raw input.
  always_ff @(posedge Clk) begin
    if (!Rst_n || clear_i) begin
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      prev_q <= din_i;
      edge_q <= din_i & ~prev_q;
    end
  end

  assign line_in = edge_q;
`else
  assign line_in = din_i;
`endif

  assign tap = line_q[delay_i];

  // Next state: shift, select tap, reload or count down the window.
  always_comb begin
    line_d = {line_q[DEPTH-2:0], line_in};
    cnt_d  = cnt_q;
    dly_d  = tap;
    win_d  = 1'b0;
    if (clear_i) begin
      line_d = '0;
      cnt_d  = '0;
      dly_d  = 1'b0;
    end else if (flush_i) begin
      // Line keeps refilling; outputs and window stay quiet until the flush ends.
      cnt_d = '0;
      dly_d = 1'b0;
    end else if (tap) begin
      cnt_d = width_i;
      win_d = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WW'(1);
      win_d = 1'b1;
    end
  end

  // Channel state registers.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      line_q <= '0;
      cnt_q  <= '0;
      dly_q  <= 1'b0;
      win_q  <= 1'b0;
    end else begin
      line_q <= line_d;
      cnt_q  <= cnt_d;
      dly_q  <= dly_d;
      win_q  <= win_d;
    end
  end

  assign dly_o = dly_q;
  assign win_o = win_q;

endmodule

// File: rtl/delay_window_gen.sv
// Per-channel programmable delay plus retriggerable window stretcher with a
// shadow/active config scheme and a DEPTH-cycle flush on Commit.
// Macro: DLY_EDGE_EN (inputs pass through a rising-edge detector; +1 cycle latency).
module delay_window_gen
  import dly_pkg::*;
#(
  parameter  int unsigned NCHAN = NCHAN_DEF,
  parameter  int unsigned DEPTH = DEPTH_DEF,
  parameter  int unsigned WW    = WW_DEF,
  localparam int unsigned DW    = $clog2(DEPTH),
  localparam int unsigned CW    = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [NCHAN-1:0] Channels,
  input  logic             CfgValid,
  output logic             CfgReady,
  input  logic [CW-1:0]    CfgChan,
  input  logic [DW-1:0]    CfgDelay,
  input  logic [WW-1:0]    CfgWidth,
  input  logic             Commit,
  output logic             Busy,
  output logic [NCHAN-1:0] DlayChann,
  output logic [NCHAN-1:0] WinChann
);

  localparam int unsigned FW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DW-1:0] delay;
    logic [WW-1:0] width;
  } chan_cfg_t;

  chan_cfg_t       shadow_q [NCHAN];
  chan_cfg_t       shadow_d [NCHAN];
  chan_cfg_t       active_q [NCHAN];
  chan_cfg_t       active_d [NCHAN];
  logic [FW-1:0]   flush_q, flush_d;
  logic            rdy_q;
  logic            busy;
  logic            cfg_hs;
  logic            chan_ok;
  logic            flush_active;

  assign busy     = (flush_q != '0);
  assign Busy     = busy;
  assign CfgReady = rdy_q & ~busy;
  assign cfg_hs   = CfgValid & CfgReady;
  assign chan_ok  = (32'(CfgChan) < NCHAN);

  // Shadow write, commit transfer and flush countdown; a write in the commit
  // cycle lands in the shadow before it is copied to active.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    flush_d  = flush_q;
    if (cfg_hs && chan_ok) begin
      shadow_d[CfgChan].delay = DW'(clamp_delay(32'(CfgDelay), DEPTH));
      shadow_d[CfgChan].width = CfgWidth;
    end
    if (Commit) begin
      active_d = shadow_d;
      flush_d  = FW'(DEPTH);
    end else if (busy) begin
      flush_d = flush_q - FW'(1);
    end
  end

  // Config and flush registers.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
      flush_q  <= '0;
      rdy_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      flush_q  <= flush_d;
      rdy_q    <= 1'b1;
    end
  end

  // Outputs are forced low on every edge that leaves Busy high.
  assign flush_active = (flush_d != '0);

  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    dly_chan #(
      .DEPTH(DEPTH),
      .WW   (WW),
      .DW   (DW)
    ) u_chan (
      .Clk    (Clk),
      .Rst_n  (Rst_n),
      .din_i  (Channels[i]),
      .delay_i(active_q[i].delay),
      .width_i(active_q[i].width),
      .clear_i(Commit),
      .flush_i(flush_active),
      .dly_o  (DlayChann[i]),
      .win_o  (WinChann[i])
    );
  end

endmodule

// File: tb/tb_delay_window_gen.sv
// Self-checking bench for delay_window_gen: cycle-accurate history model plus
// directed vectors with literal expectations. Honours DLY_EDGE_EN.
module tb_delay_window_gen;

  localparam int NCHAN = 4;
  localparam int DEPTH = 16;
  localparam int WW    = 4;
  localparam int DW    = 4;
  localparam int CW    = 2;
  localparam int HMAX  = 4096;
`ifdef DLY_EDGE_EN
  localparam int E = 1;
`else
  localparam int E = 0;
`endif

  logic             Clk = 1'b0;
  logic             Rst_n = 1'b0;
  logic [NCHAN-1:0] Channels = '0;
  logic             CfgValid = 1'b0;
  logic             CfgReady;
  logic [CW-1:0]    CfgChan = '0;
  logic [DW-1:0]    CfgDelay = '0;
  logic [WW-1:0]    CfgWidth = '0;
  logic             Commit = 1'b0;
  logic             Busy;
  logic [NCHAN-1:0] DlayChann;
  logic [NCHAN-1:0] WinChann;

  delay_window_gen #(.NCHAN(NCHAN), .DEPTH(DEPTH), .WW(WW)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Channels (Channels),
    .CfgValid (CfgValid),
    .CfgReady (CfgReady),
    .CfgChan  (CfgChan),
    .CfgDelay (CfgDelay),
    .CfgWidth (CfgWidth),
    .Commit   (Commit),
    .Busy     (Busy),
    .DlayChann(DlayChann),
    .WinChann (WinChann)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- model: histories of samples since the last clear ----------------
  int  n_edge = -1;
  bit  model_on = 1'b0;
  int  sh_d [NCHAN], sh_w [NCHAN], ac_d [NCHAN], ac_w [NCHAN];
  int  flush_rem = 0, last_clear = 0, last_block = 0;
  bit  rdy_m = 1'b0;
  bit  in_h  [NCHAN][HMAX];
  bit  s_h   [NCHAN][HMAX];
  bit  sel_h [NCHAN][HMAX];
  logic [NCHAN-1:0] exp_dly, exp_win;
  logic             exp_busy, exp_rdy;
  logic [NCHAN-1:0] rec_dly [HMAX];
  logic [NCHAN-1:0] rec_win [HMAX];
  logic             rec_busy [HMAX];

  always @(posedge Clk) begin
    int n, src;
    bit hs, prev, w;
    n_edge++;
    n = n_edge;
    if (!Rst_n) begin
      model_on = 1'b1;
      for (int c = 0; c < NCHAN; c++) begin
        sh_d[c] = 0; sh_w[c] = 0; ac_d[c] = 0; ac_w[c] = 0;
        sel_h[c][n] = 1'b0;
      end
      flush_rem = 0; last_clear = n; last_block = n; rdy_m = 1'b0;
      exp_dly = '0; exp_win = '0; exp_busy = 1'b0; exp_rdy = 1'b0;
    end else if (model_on) begin
      hs = CfgValid && rdy_m && (flush_rem == 0);
      if (hs && int'(CfgChan) < NCHAN) begin
        sh_d[CfgChan] = (int'(CfgDelay) > DEPTH - 1) ? DEPTH - 1 : int'(CfgDelay);
        sh_w[CfgChan] = int'(CfgWidth);
      end
      if (Commit) begin
        ac_d = sh_d; ac_w = sh_w; flush_rem = DEPTH; last_clear = n;
      end else if (flush_rem > 0) begin
        flush_rem--;
      end
      rdy_m = 1'b1;
      if (flush_rem > 0) last_block = n;
      for (int c = 0; c < NCHAN; c++) begin
        in_h[c][n] = Channels[c];
        prev = (n - 1 > last_clear) ? in_h[c][n-1] : 1'b0;
        s_h[c][n] = (E != 0) ? (in_h[c][n] & ~prev) : in_h[c][n];
        src = n - 1 - ac_d[c] - E;
        sel_h[c][n] = (src > last_clear) ? s_h[c][src] : 1'b0;
        w = 1'b0;
        for (int k = 0; k <= ac_w[c]; k++)
          if (n - k > last_block && sel_h[c][n-k]) w = 1'b1;
        exp_dly[c] = (flush_rem > 0) ? 1'b0 : sel_h[c][n];
        exp_win[c] = (flush_rem > 0) ? 1'b0 : w;
      end
      exp_busy = (flush_rem > 0);
      exp_rdy  = ~exp_busy;
    end
    #1;
    rec_dly[n] = DlayChann; rec_win[n] = WinChann; rec_busy[n] = Busy;
    if (model_on) begin
      chk("cyc_dly",   32'(DlayChann), 32'(exp_dly));
      chk("cyc_win",   32'(WinChann),  32'(exp_win));
      chk("cyc_busy",  32'(Busy),      32'(exp_busy));
      chk("cyc_ready", 32'(CfgReady),  32'(exp_rdy));
    end
  end

  // ---------------- driver helpers (all start and end just after a negedge) ----------------
  task automatic cfg_write(input int ch, input int d, input int w);
    CfgValid = 1'b1; CfgChan = CW'(ch); CfgDelay = DW'(d); CfgWidth = WW'(w);
    @(negedge Clk);
    CfgValid = 1'b0;
  endtask

  task automatic do_commit(output int t);
    Commit = 1'b1;
    @(posedge Clk); #2; t = n_edge;
    @(negedge Clk);
    Commit = 1'b0;
  endtask

  task automatic wait_idle();
    int i = 0;
    while (Busy === 1'b1 && i < 100) begin @(negedge Clk); i++; end
    chk("wait_idle_timeout", 32'(Busy), 32'(0));
  endtask

  task automatic pulse(input int ch, output int t);
    Channels[ch] = 1'b1;
    @(posedge Clk); #2; t = n_edge;
    @(negedge Clk);
    Channels[ch] = 1'b0;
  endtask

  // Literal span: signal (0 dly, 1 win, 2 busy) high exactly for offsets first..last.
  task automatic check_span(input string name, input int which, input int ch, input int t,
                            input int first, input int last, input int horizon);
    logic v, e;
    while (n_edge < t + horizon) @(negedge Clk);
    for (int k = 0; k <= horizon; k++) begin
      v = (which == 0) ? rec_dly[t+k][ch] : (which == 1) ? rec_win[t+k][ch] : rec_busy[t+k];
      e = (k >= first && k <= last);
      chk($sformatf("%s+%0d", name, k), 32'(v), 32'(e));
    end
  endtask

  logic [NCHAN-1:0] pat [16] = '{4'h1, 4'h3, 4'h0, 4'h6, 4'hF, 4'h0, 4'h0, 4'h9,
                                 4'h2, 4'h2, 4'h0, 4'h5, 4'hA, 4'h0, 4'h8, 4'h1};

  initial begin
    int t, t2, tc;
    // Reset
    @(posedge Clk); #2;
    chk("rst_busy", 32'(Busy), 32'(0));
    chk("rst_ready", 32'(CfgReady), 32'(0));
    chk("rst_dly", 32'(DlayChann), 32'(0));
    chk("rst_win", 32'(WinChann), 32'(0));
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk); #2;
    chk("rdy_after_rst", 32'(CfgReady), 32'(1));
    @(negedge Clk);

    // Ch0 delay 3, width 0
    cfg_write(0, 3, 0);
    do_commit(tc);
    wait_idle();
    pulse(0, t);
    check_span("t1_dly", 0, 0, t, 4 + E, 4 + E, 7);
    check_span("t1_win", 1, 0, t, 4 + E, 4 + E, 7);

    // Ch1 delay 0, width 5, retriggered
    cfg_write(1, 0, 5);
    do_commit(tc);
    wait_idle();
    pulse(1, t);
    repeat (2) @(negedge Clk);
    pulse(1, t2);
    check_span("t2_win", 1, 1, t, 1 + E, 9 + E, 12);

    // Ch2 shadow write does not take effect until Commit
    cfg_write(2, 7, 0);
    pulse(2, t);
    check_span("t3_pre", 0, 2, t, 1 + E, 1 + E, 10);
    do_commit(tc);
    check_span("t3_busy", 2, 0, tc, 0, 15, 17);
    wait_idle();
    pulse(2, t);
    check_span("t3_post", 0, 2, t, 8 + E, 8 + E, 11);

    // Write attempt during Busy is refused
    do_commit(tc);
    chk("t4_ready_busy", 32'(CfgReady), 32'(0));
    cfg_write(0, 9, 3);
    wait_idle();
    pulse(0, t);
    check_span("t4_dly", 0, 0, t, 4 + E, 4 + E, 12);

    // Write and Commit in the same cycle
    CfgValid = 1'b1; CfgChan = 2'd0; CfgDelay = 4'd5; CfgWidth = 4'd1; Commit = 1'b1;
    @(negedge Clk);
    CfgValid = 1'b0; Commit = 1'b0;
    wait_idle();
    pulse(0, t);
    check_span("t5_dly", 0, 0, t, 6 + E, 6 + E, 10);
    check_span("t5_win", 1, 0, t, 6 + E, 7 + E, 10);

    // Reset in the middle of a flush
    do_commit(tc);
    repeat (5) @(negedge Clk);
    chk("t6_busy_mid", 32'(Busy), 32'(1));
    Rst_n = 1'b0;
    @(posedge Clk); #2;
    chk("t6_busy", 32'(Busy), 32'(0));
    chk("t6_dly", 32'(DlayChann), 32'(0));
    chk("t6_win", 32'(WinChann), 32'(0));
    chk("t6_ready", 32'(CfgReady), 32'(0));
    @(negedge Clk);
    Rst_n = 1'b1;
    pulse(0, t);
    check_span("t6_dly0", 0, 0, t, 1 + E, 1 + E, 5);
    check_span("t6_win0", 1, 0, t, 1 + E, 1 + E, 5);

    // Held-high input on ch3, width 2
    cfg_write(3, 0, 2);
    do_commit(tc);
    wait_idle();
    Channels[3] = 1'b1;
    @(posedge Clk); #2; t = n_edge;
    repeat (9) @(posedge Clk);
    @(negedge Clk);
    Channels[3] = 1'b0;
    if (E != 0) check_span("t7_hold", 1, 3, t, 2, 4, 16);
    else        check_span("t7_hold", 1, 3, t, 1, 12, 16);

    // Boundaries: max delay and max width
    cfg_write(1, 15, 3);
    cfg_write(2, 1, 15);
    cfg_write(0, 2, 1);
    do_commit(tc);
    wait_idle();
    pulse(1, t);
    check_span("t8_dmax", 0, 1, t, 16 + E, 16 + E, 20);
    pulse(2, t);
    check_span("t8_wmax", 1, 2, t, 2 + E, 17 + E, 20);

    // Multi-channel directed pattern, checked by the model every cycle
    for (int i = 0; i < 16; i++) begin
      Channels = pat[i];
      @(negedge Clk);
    end
    Channels = '0;
    repeat (40) @(negedge Clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
